fa_pipe_addsub: RTL and testbench
=================================

# fa_pipe_addsub

Parametrised, pipelined unsigned add/subtract unit for the matrix-multiply datapath. It replaces the fixed 20-bit single-cycle ripple adder with these features:
- configurable width;
- a carry chain split into registered segments;
- a subtract mode;
- carry-out/overflow reporting;
- a valid/ready handshake with full-pipeline stall.

It sits between the partial-product XOR/AND stage and the accumulator register file.

## Interface
- WIDTH, 20: operand and result width in bits.
- SEG_W, 5: bits per pipeline segment. WIDTH must be a multiple of SEG_W; elaboration fails otherwise.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  unsigned overflow (add with cout=1) or underflow (sub with cout=0).

## Operation
- NSEG = WIDTH/SEG_W. Stage k adds bits [k·SEG_W +: SEG_W] using the carry registered from stage k−1.
- Stage 0 carry-in = sub. B is inverted when sub=1 (two's-complement subtract).
- Each stage carries forward:
  - its valid bit;
  - the sub flag;
  - the completed low result bits;
  - the unconsumed upper operand bits;
  - its carry.
- Global advance = !out_valid || out_ready. All stages shift together on advance and hold otherwise.
- in_ready = advance. A beat is accepted when in_valid && in_ready.
- An empty slot enters stage 0 when advance=1 and in_valid=0, creating a bubble. Bubbles propagate but never raise out_valid.
- Final-stage outputs are registered: sum, cout and ovf are stable while out_valid && !out_ready.
- Arithmetic is modulo 2^WIDTH. cout and ovf are computed from the full-width carry chain.
- Simultaneous accept and emit when the pipe is full and out_ready=1 is legal: throughput is 1 beat/cycle.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - all stage valid bits = 0; out_valid = 0;
  - sum = 0; cout = 0; ovf = 0;
  - in_ready = 1 from the first edge after deassert.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSEG−1, i.e. NSEG cycles including the accepting edge. With WIDTH=20 and SEG_W=5 the latency is 4.
- When NSEG=1 the unit degenerates to a registered single-stage adder with latency 1.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational). No beat is lost or duplicated.
- Reset asserted mid-operation discards all in-flight beats immediately. Partial results are never emitted.
- in_valid/a/b/sub may change freely while in_ready=0. They are sampled only on an accepting edge.

## Configuration
- FA_PIPE_ADDSUB_SAT_EN defined: results saturate on overflow.
  - Add overflow → sum = all ones.
  - Subtract underflow → sum = 0.
  - cout and ovf are still reported unchanged.
  - The saturation mux sits before the output register, so latency is unchanged.
- Not defined: sum wraps modulo 2^WIDTH. ovf and cout are still driven.

## Structure
- Shared package fa_pkg:
  - FA_DEF_WIDTH = 20 and FA_DEF_SEG_W = 5;
  - the op_e typedef (OP_ADD=0, OP_SUB=1);
  - the function computing NSEG.
- Sub-module fa_seg: combinational SEG_W-bit ripple adder built from the existing FullAdder cell (a, b, cin → sum, cout). It is instantiated NSEG times by a generate loop.
- The top level holds:
  - the stage registers;
  - the advance/handshake logic;
  - the optional saturation logic.

## Test plan
All scenarios use WIDTH=20, SEG_W=5, out_ready=1 unless stated.
- Add 0xFFFFF + 0x00001 → 4 cycles later sum=0x00000, cout=1, ovf=1. With SAT_EN, sum=0xFFFFF.
- Sub 0x00005 − 0x00007 → sum=0xFFFFE, cout=0, ovf=1. With SAT_EN, sum=0x00000. Sub 7 − 5 → sum=0x00002, cout=1, ovf=0.
- Segment-boundary carry: add 0x0001F + 0x00001 → sum=0x00020, ovf=0. Add 0x7FFFF + 0x00001 → sum=0x80000.
- Back-to-back: 6 beats on consecutive cycles (1+1, 2+2, … 6+6) → out_valid high 6 consecutive cycles starting at latency 4, sums 2, 4, … 12 in order.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles → in_ready=0 throughout, sum held constant. Release → results drain in order with none dropped or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle → out_valid=0, sum=0 immediately. No stale result is emitted after release; the next beat completes normally with latency 4.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared definitions for the pipelined add/subtract unit: default geometry,
// operation encoding and the segment-count helper.
package fa_pkg;

    localparam int FA_DEF_WIDTH = 20;
    localparam int FA_DEF_SEG_W = 5;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of carry-chain segments (and therefore pipeline stages).
    function automatic int fa_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell shared by the arithmetic datapaths.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fa_seg.sv
// One combinational segment of the carry chain: a SEG_W-bit ripple adder
// built from FullAdder cells.
module fa_seg
    import fa_pkg::*;
#(
    parameter int SEG_W = FA_DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    logic [SEG_W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        FullAdder u_fa (
            .a    (a_i[i]),
            .b    (b_i[i]),
            .cin  (carry[i]),
            .sum  (sum_o[i]),
            .cout (carry[i+1])
        );
    end

    assign cout_o = carry[SEG_W];

endmodule

// File: rtl/fa_pipe_addsub.sv
// Pipelined unsigned add/subtract unit. The carry chain is cut into NSEG
// registered segments; every stage shifts together on a global advance and
// the final stage doubles as the output register.
// Optional feature: define FA_PIPE_ADDSUB_SAT_EN to saturate the result on
// overflow (all ones) or underflow (zero) instead of wrapping.
module fa_pipe_addsub
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEF_WIDTH,
    parameter int SEG_W = FA_DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = fa_nseg(WIDTH, SEG_W);
    localparam int LAST = NSEG - 1;

    if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_cfg
        $error("fa_pipe_addsub: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Stage k state after the edge that completed segment k. x holds the
    // finished low result bits followed by the still-unconsumed A bits; y
    // holds B, already inverted for subtract.
    logic             valid_q [NSEG];
    op_e              op_q    [NSEG];
    logic             carry_q [NSEG];
    logic [WIDTH-1:0] x_q     [NSEG];
    logic [WIDTH-1:0] y_q     [NSEG];
    logic             ovf_q;

    // Values presented to each stage's segment adder.
    logic             valid_d  [NSEG];
    op_e              op_d     [NSEG];
    logic             carry_in [NSEG];
    logic [WIDTH-1:0] x_in     [NSEG];
    logic [WIDTH-1:0] y_d      [NSEG];
    logic [SEG_W-1:0] seg_sum  [NSEG];
    logic             seg_cout [NSEG];

    logic [WIDTH-1:0] x_d [NSEG];
    logic             ovf_d;
    logic             advance;

    // The whole pipe moves unless a finished result is waiting on the consumer.
    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    for (genvar g = 0; g < NSEG; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign valid_d[g]  = in_valid;
            assign op_d[g]     = op_e'(sub);
            assign carry_in[g] = sub;
            assign x_in[g]     = a;
            assign y_d[g]      = b ^ {WIDTH{sub}};
        end else begin : g_link
            assign valid_d[g]  = valid_q[g-1];
            assign op_d[g]     = op_q[g-1];
            assign carry_in[g] = carry_q[g-1];
            assign x_in[g]     = x_q[g-1];
            assign y_d[g]      = y_q[g-1];
        end

        fa_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a_i    (x_in[g][g*SEG_W +: SEG_W]),
            .b_i    (y_d[g][g*SEG_W +: SEG_W]),
            .cin_i  (carry_in[g]),
            .sum_o  (seg_sum[g]),
            .cout_o (seg_cout[g])
        );
    end

    // Merge each segment result into its word; flag and optionally saturate at the last stage.
    always_comb begin
        // NOTE: every output of this block is assigned before any condition so no latch is inferred.
        for (int k = 0; k < NSEG; k++) begin
            x_d[k]                     = x_in[k];
            x_d[k][k*SEG_W +: SEG_W]   = seg_sum[k];
        end
        ovf_d = (op_d[LAST] == OP_SUB) ? !seg_cout[LAST] : seg_cout[LAST];
`ifdef FA_PIPE_ADDSUB_SAT_EN
        if (ovf_d) begin
            x_d[LAST] = (op_d[LAST] == OP_SUB) ? '0 : '1;
        end
`endif
    end

    // Stage registers: cleared on reset, shift together on advance, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the stage arrays are pipeline state, not storage, so every entry is reset to drop in-flight beats.
            for (int k = 0; k < NSEG; k++) begin
                valid_q[k] <= 1'b0;
                op_q[k]    <= OP_ADD;
                carry_q[k] <= 1'b0;
                x_q[k]     <= '0;
                y_q[k]     <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage read the pre-edge value of the one behind it.
            for (int k = 0; k < NSEG; k++) begin
                valid_q[k] <= valid_d[k];
                op_q[k]    <= op_d[k];
                carry_q[k] <= seg_cout[k];
                x_q[k]     <= x_d[k];
                y_q[k]     <= y_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = x_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fa_pipe_addsub.sv
// Scoreboard bench for fa_pipe_addsub at WIDTH=20, SEG_W=5. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fa_pipe_addsub;
    import fa_pkg::*;

    localparam int W   = 20;
    localparam int SW  = 5;
    localparam int LAT = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t mon_b;

    fa_pipe_addsub #(
        .WIDTH (W),
        .SEG_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result that is transferred on the coming edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_b.sum  = sum;
            mon_b.cout = cout;
            mon_b.ovf  = ovf;
            mon_b.cyc  = cyc;
            obs_q.push_back(mon_b);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion before 400000");
        $fatal(1);
    end

    // Reference arithmetic, written independently of the segmented chain.
    function automatic beat_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic s, input int acc_cyc);
        beat_t        r;
        logic [W:0]   full;
        if (s) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            r.ovf  = (x < y);
        end else begin
            full   = {1'b0, x} + {1'b0, y};
            r.sum  = full[W-1:0];
            r.cout = full[W];
            r.ovf  = full[W];
        end
`ifdef FA_PIPE_ADDSUB_SAT_EN
        if (r.ovf) r.sum = s ? '0 : '1;
`endif
        r.cyc = acc_cyc;
        return r;
    endfunction

    // Present one beat and hold it until accepted; queue its expected result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end else begin
            exp_q.push_back(model(x, y, s, cyc + 1));
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic wait_obs(input int n, input string tag);
        int t = 0;
        while (obs_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (obs_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: results=%0d, required %0d", tag, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h, required 00000", sum);
        end
        checks++;
        if ({cout, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got cout=%b ovf=%b, required 0 0", cout, ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_overflow();
        beat_t e;
        beat_t o;
        send(20'hFFFFF, 20'h00001, 1'b0);
        send(20'h00005, 20'h00007, 1'b1);
        send(20'h00007, 20'h00005, 1'b1);
        send(20'hFFFFF, 20'hFFFFF, 1'b0);
        idle();
        wait_obs(4, "overflow");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL overflow: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (o.cyc - e.cyc !== LAT - 1) begin
                errors++;
                $display("FAIL overflow_latency: got %0d edges, required %0d", o.cyc - e.cyc, LAT - 1);
            end
        end
    endtask

    task automatic test_seg_carry();
        beat_t e;
        beat_t o;
        send(20'h0001F, 20'h00001, 1'b0);
        send(20'h7FFFF, 20'h00001, 1'b0);
        send(20'h00020, 20'h00001, 1'b1);
        send(20'h12345, 20'h12345, 1'b1);
        send(20'h003FF, 20'h00001, 1'b0);
        idle();
        wait_obs(5, "seg_carry");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL seg_carry: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (o.cyc - e.cyc !== LAT - 1) begin
                errors++;
                $display("FAIL seg_carry_latency: got %0d edges, required %0d", o.cyc - e.cyc, LAT - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        beat_t o;
        int    first = -1;
        int    idx   = 0;
        for (int i = 1; i <= 6; i++) send(W'(i), W'(i), 1'b0);
        idle();
        wait_obs(6, "back_to_back");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (first < 0) first = o.cyc;
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {W'(2 * (idx + 1)), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL back_to_back: got sum=%h cout=%b ovf=%b, required sum=%h cout=0 ovf=0",
                         o.sum, o.cout, o.ovf, W'(2 * (idx + 1)));
            end
            checks++;
            if (o.cyc !== first + idx || o.cyc - e.cyc !== LAT - 1) begin
                errors++;
                $display("FAIL back_to_back_timing: got cycle %0d latency %0d, required cycle %0d latency %0d",
                         o.cyc, o.cyc - e.cyc, first + idx, LAT - 1);
            end
            idx++;
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        beat_t o;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(20'h11111, 20'h00001, 1'b0);
        send(20'h22222, 20'h00002, 1'b1);
        send(20'hF0000, 20'h20000, 1'b0);
        send(20'h00003, 20'h00009, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            sub      = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid} !== 2'b01) begin
                errors++;
                $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
            end
            checks++;
            if ({sum, cout, ovf} !== {exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf}) begin
                errors++;
                $display("FAIL stall_hold: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(20'h00055, 20'h000AA, 1'b0);
        idle();
        wait_obs(5, "backpressure");
        repeat (8) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL backpressure_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL backpressure_order: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_reset_midflight();
        beat_t e;
        beat_t o;
        send(20'h00100, 20'h00200, 1'b0);
        send(20'h00300, 20'h00400, 1'b0);
        send(20'h00500, 20'h00600, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum} !== {1'b0, W'(0)}) begin
            errors++;
            $display("FAIL midflight_reset: got out_valid=%b sum=%h, required 0 00000", out_valid, sum);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d results after reset, required 0", obs_q.size());
        end
        obs_q.delete();
        send(20'hABCDE, 20'h11111, 1'b0);
        idle();
        wait_obs(1, "midflight");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.sum, o.cout, o.ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL midflight_next: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (o.cyc - e.cyc !== LAT - 1) begin
                errors++;
                $display("FAIL midflight_latency: got %0d edges, required %0d", o.cyc - e.cyc, LAT - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_seg_carry();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
